conv3x3_stream: RTL and testbench
=================================

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 12, pixel and result width in bits.
REQ-002 SHALL have parameter LINE_W, default 640, pixels per image line (>= 4).
REQ-003 SHALL have port iCLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port iDVAL  input  1  input pixel valid, one pixel accepted per cycle when high.
REQ-006 SHALL have port iSOF  input  1  start of frame, qualified by iDVAL, marks pixel (0,0).
REQ-007 SHALL have port iMODE  input  2  00 Gx (vertical Sobel), 01 Gy (horizontal Sobel), 10 |Gx|+|Gy|, 11 passthrough of window centre.
REQ-008 SHALL have port iTH_EN  input  1  threshold enable.
REQ-009 SHALL have port iTHRESH  input  DATA_W  threshold level, unsigned.
REQ-010 SHALL have port iDATA  input  DATA_W  unsigned input pixel.
REQ-011 SHALL have port oDVAL  output  1  result valid.
REQ-012 SHALL have port oSOF  output  1  iSOF delayed alongside oDVAL.
REQ-013 SHALL have port oDATA  output  DATA_W  unsigned result.

Function
REQ-014 SHALL hold two internal line buffers of LINE_W x DATA_W, advanced only on iDVAL, forming a 3x3 window whose bottom-right tap is the accepted pixel.
REQ-015 SHALL advance window column registers only on iDVAL; iDVAL low cycles SHALL not alter window, counters or line buffers.
REQ-016 SHALL keep column counter 0..LINE_W-1, wrapping to 0 and incrementing row counter; row counter SHALL saturate at 2.
REQ-017 SHALL force column and row counters to 0 for a pixel accepted with iSOF=1, regardless of prior count.
REQ-018 SHALL sample iMODE, iTH_EN and iTHRESH with each accepted pixel and carry them through the pipeline.
REQ-019 SHALL compute Gx = (TR+2MR+BR)-(TL+2ML+BL) and Gy = (BL+2BM+BR)-(TL+2TM+TR) in signed DATA_W+4 bits, no internal overflow.
REQ-020 SHALL take absolute value of the selected result (mode 10: |Gx|+|Gy|) and saturate to 2^DATA_W-1.
REQ-021 SHALL, in mode 11, output the window centre pixel unmodified.
REQ-022 SHALL, when iTH_EN=1, output 2^DATA_W-1 if the saturated result >= iTHRESH, else 0.
REQ-023 SHALL output 0 for any pixel with row counter < 2 or column counter < 2 (border mask), all modes.
REQ-024 SHALL have fixed latency 2 cycles: oDVAL/oSOF/oDATA for a pixel accepted at cycle N appear at cycle N+2, one output per accepted input, order preserved.
REQ-025 SHALL drive oDATA to 0 whenever oDVAL is 0.

Reset
REQ-026 SHALL, on iRST high, asynchronously clear counters, window registers, pipeline registers, oDVAL, oSOF and oDATA to 0.
REQ-027 SHALL not require clearing line buffer storage; border masking (REQ-023) SHALL hide stale contents.
REQ-028 SHALL, after reset released mid-frame, treat the next accepted pixel as (0,0) whether or not iSOF is set.

Verification (DATA_W=12, LINE_W=8)
REQ-029 Flat frame, all pixels 100, mode 00 -> every oDATA 0; 64 outputs, each 2 cycles after its input.
REQ-030 Pixel=0 for col<4 else 1000, mode 00 -> oDATA 4000 at cols 4,5 of rows >= 2, 0 elsewhere; same frame mode 01 -> all 0.
REQ-031 Pixel=0 for row<4 else 1000, mode 10 -> 4000 at rows 4,5 cols >= 2; with iTH_EN=1, iTHRESH=2000 -> 4095 there, 0 elsewhere.
REQ-032 Pixel=0 for col<4 else 4095, mode 00 -> 16380 saturated to 4095 at cols 4,5; mode 11 -> centre pixel values, 0 in border.
REQ-033 Repeat REQ-030 with random iDVAL gaps (up to 5 cycles) -> identical output value sequence, oDVAL count equals input count.
REQ-034 Assert iRST during row 3 -> oDVAL, oDATA 0 same cycle; after release, first 2 rows of outputs 0, then REQ-030 values on fresh frame.

Source files
------------

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 Sobel / passthrough filter with threshold and border mask
module conv3x3_stream #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
  input  logic              iTH_EN,
  input  logic [DATA_W-1:0] iTHRESH,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oDVAL,
  output logic              oSOF,
  output logic [DATA_W-1:0] oDATA
);

  localparam int CW = $clog2(LINE_W);
  localparam int SW = DATA_W + 4;
  localparam logic [CW-1:0]     COL_LAST = CW'(LINE_W - 1);
  localparam logic [1:0]        MODE_GX   = 2'b00;
  localparam logic [1:0]        MODE_GY   = 2'b01;
  localparam logic [1:0]        MODE_SUM  = 2'b10;
  localparam logic [DATA_W-1:0] PIX_MAX   = {DATA_W{1'b1}};
  localparam logic [SW-1:0]     MAG_MAX   = {4'b0000, PIX_MAX};

  logic [DATA_W-1:0] line1 [LINE_W];
  logic [DATA_W-1:0] line2 [LINE_W];

  logic [CW-1:0]     col_cnt;
  logic [1:0]        row_cnt;
  logic [CW-1:0]     pix_col;
  logic [1:0]        pix_row;
  logic [DATA_W-1:0] up1;
  logic [DATA_W-1:0] up2;

  logic [DATA_W-1:0] w_tl, w_tm, w_tr;
  logic [DATA_W-1:0] w_ml, w_mm, w_mr;
  logic [DATA_W-1:0] w_bl, w_bm, w_br;

  logic              s1_dval;
  logic              s1_sof;
  logic [1:0]        s1_mode;
  logic              s1_th_en;
  logic [DATA_W-1:0] s1_thresh;
  logic              s1_border;

  logic signed [SW-1:0] gx;
  logic signed [SW-1:0] gy;
  logic [SW-1:0]        ax;
  logic [SW-1:0]        ay;
  logic [SW-1:0]        sel_mag;
  logic [DATA_W-1:0]    sat;
  logic [DATA_W-1:0]    thr;
  logic [DATA_W-1:0]    res;

  // Position of the pixel being accepted now; SOF restarts the frame wherever the counters were.
  always_comb begin
    pix_col = iSOF ? '0 : col_cnt;
    pix_row = iSOF ? 2'd0 : row_cnt;
  end

  assign up1 = line1[pix_col];
  assign up2 = line2[pix_col];

  // Line storage is never reset; the border mask hides whatever it holds after power-up.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      line1[pix_col] <= iDATA;
      line2[pix_col] <= up1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_cnt <= '0;
      row_cnt <= 2'd0;
    end else if (iDVAL) begin
      if (pix_col == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (pix_row == 2'd2) ? 2'd2 : pix_row + 2'd1;
      end else begin
        col_cnt <= pix_col + CW'(1);
        row_cnt <= pix_row;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      w_tl      <= '0;
      w_tm      <= '0;
      w_tr      <= '0;
      w_ml      <= '0;
      w_mm      <= '0;
      w_mr      <= '0;
      w_bl      <= '0;
      w_bm      <= '0;
      w_br      <= '0;
      s1_dval   <= 1'b0;
      s1_sof    <= 1'b0;
      s1_mode   <= 2'b00;
      s1_th_en  <= 1'b0;
      s1_thresh <= '0;
      s1_border <= 1'b0;
    end else begin
      s1_dval <= iDVAL;
      if (iDVAL) begin
        w_tl      <= w_tm;
        w_tm      <= w_tr;
        w_tr      <= up2;
        w_ml      <= w_mm;
        w_mm      <= w_mr;
        w_mr      <= up1;
        w_bl      <= w_bm;
        w_bm      <= w_br;
        w_br      <= iDATA;
        s1_sof    <= iSOF;
        s1_mode   <= iMODE;
        s1_th_en  <= iTH_EN;
        s1_thresh <= iTHRESH;
        s1_border <= (pix_row < 2'd2) || (pix_col < CW'(2));
      end
    end
  end

  function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  always_comb begin
    gx = (ext(w_tr) + (ext(w_mr) <<< 1) + ext(w_br))
       - (ext(w_tl) + (ext(w_ml) <<< 1) + ext(w_bl));
    gy = (ext(w_bl) + (ext(w_bm) <<< 1) + ext(w_br))
       - (ext(w_tl) + (ext(w_tm) <<< 1) + ext(w_tr));
    ax = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    case (s1_mode)
      MODE_GX:  sel_mag = ax;
      MODE_GY:  sel_mag = ay;
      MODE_SUM: sel_mag = ax + ay;
      default:  sel_mag = {4'b0000, w_mm};
    endcase
    sat = (sel_mag > MAG_MAX) ? PIX_MAX : sel_mag[DATA_W-1:0];
    if (s1_th_en) begin
      thr = (sat >= s1_thresh) ? PIX_MAX : '0;
    end else begin
      thr = sat;
    end
    res = s1_border ? '0 : thr;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oSOF  <= 1'b0;
      oDATA <= '0;
    end else begin
      oDVAL <= s1_dval;
      oSOF  <= s1_dval & s1_sof;
      oDATA <= s1_dval ? res : '0;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - self-checking bench for conv3x3_stream against a frame-level model
module tb_conv3x3_stream;

  localparam int DW = 12;
  localparam int LW = 8;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iDVAL;
  logic          iSOF;
  logic [1:0]    iMODE;
  logic          iTH_EN;
  logic [DW-1:0] iTHRESH;
  logic [DW-1:0] iDATA;
  logic          oDVAL;
  logic          oSOF;
  logic [DW-1:0] oDATA;

  conv3x3_stream #(.DATA_W(DW), .LINE_W(LW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iSOF(iSOF), .iMODE(iMODE),
    .iTH_EN(iTH_EN), .iTHRESH(iTHRESH), .iDATA(iDATA),
    .oDVAL(oDVAL), .oSOF(oSOF), .oDATA(oDATA)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int data;
    int sof;
    int due;
  } exp_t;

  typedef struct {
    string name;
    int    pat;
    int    mode;
    int    th_en;
    int    th;
    int    gaps;
    int    nz_val;
    int    nz_cnt;
  } vec_t;

  exp_t q[$];
  int   img[64][LW];
  int   idx;
  int   ecount;
  int   errors;
  int   checks;
  int   out_cnt;
  int   nz_cnt;
  int   nz_bad;
  int   cur_nz;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected result straight from the Sobel definition over the stored image.
  function automatic int ref_out(input int r, input int c, input int mode, input int th_en, input int th);
    int w[3][3];
    int gx, gy, m;
    if (r < 2 || c < 2) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = img[(r - 2 + i) % 64][c - 2 + j];
    gx = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
    gy = (w[2][0] + 2 * w[2][1] + w[2][2]) - (w[0][0] + 2 * w[0][1] + w[0][2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (mode)
      0:       m = gx;
      1:       m = gy;
      2:       m = gx + gy;
      default: m = w[1][1];
    endcase
    if (m > 4095) m = 4095;
    if (th_en != 0) m = (m >= th) ? 4095 : 0;
    return m;
  endfunction

  function automatic int pix(input int p, input int r, input int c);
    case (p)
      0:       return 100;
      1:       return (c < 4) ? 0 : 1000;
      2:       return (r < 4) ? 0 : 1000;
      3:       return (c < 4) ? 0 : 4095;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  // Model: records every accepted pixel and schedules its expected output.
  initial begin : model
    exp_t e;
    int r, c;
    idx = 0;
    ecount = 0;
    forever begin
      @(posedge iCLK);
      ecount++;
      if (iRST) begin
        idx = 0;
      end else if (iDVAL) begin
        if (iSOF) idx = 0;
        r = idx / LW;
        c = idx % LW;
        img[r % 64][c] = int'(iDATA);
        e.data = ref_out(r, c, int'(iMODE), int'(iTH_EN), int'(iTHRESH));
        e.sof  = int'(iSOF);
        e.due  = ecount + 1;
        q.push_back(e);
        idx++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int ev;
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        check("rst_odval", int'(oDVAL), 0);
        check("rst_odata", int'(oDATA), 0);
        q.delete();
      end else begin
        ev = (q.size() > 0 && q[0].due == ecount) ? 1 : 0;
        check("odval", int'(oDVAL), ev);
        if (ev != 0) begin
          e = q.pop_front();
          if (oDVAL) begin
            check("odata", int'(oDATA), e.data);
            check("osof", int'(oSOF), e.sof);
            out_cnt++;
            if (oDATA != 0) begin
              nz_cnt++;
              if (int'(oDATA) != cur_nz) nz_bad++;
            end
          end
        end else if (!oDVAL) begin
          check("idle_zero", int'(oDATA), 0);
        end
        while (q.size() > 0 && q[0].due < ecount) void'(q.pop_front());
      end
    end
  end

  task automatic send_frame(input int p, input int mode, input int th_en, input int th,
                            input int gaps, input int sof_first, input int npix);
    int n;
    for (int k = 0; k < npix; k++) begin
      iDVAL   = 1'b1;
      iSOF    = (k == 0 && sof_first != 0);
      iDATA   = DW'(pix(p, k / LW, k % LW));
      iMODE   = (mode < 0) ? 2'($urandom_range(0, 3)) : 2'(mode);
      iTH_EN  = (th_en != 0);
      iTHRESH = DW'(th);
      @(posedge iCLK);
      #1;
      iDVAL = 1'b0;
      iSOF  = 1'b0;
      iDATA = DW'($urandom);
      iMODE = 2'($urandom);
      if (gaps != 0) begin
        n = int'($urandom_range(0, 5));
        repeat (n) begin
          @(posedge iCLK);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge iCLK);
      n++;
    end
    #1;
    check("drain", q.size(), 0);
  endtask

  task automatic clear_stats(input int nzv);
    out_cnt = 0;
    nz_cnt  = 0;
    nz_bad  = 0;
    cur_nz  = nzv;
  endtask

  task automatic frame_stats(input string name, input int nzc);
    check({name, "_count"}, out_cnt, 64);
    check({name, "_nz_cnt"}, nz_cnt, nzc);
    check({name, "_nz_val"}, nz_bad, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t tbl[10];
    tbl[0] = '{"flat_gx",       0, 0, 0, 0,    0, 0,    0};
    tbl[1] = '{"colstep_gx",    1, 0, 0, 0,    0, 4000, 12};
    tbl[2] = '{"colstep_gy",    1, 1, 0, 0,    0, 0,    0};
    tbl[3] = '{"rowstep_sum",   2, 2, 0, 0,    0, 4000, 12};
    tbl[4] = '{"rowstep_th",    2, 2, 1, 2000, 0, 4095, 12};
    tbl[5] = '{"rowstep_th_eq", 2, 2, 1, 4000, 0, 4095, 12};
    tbl[6] = '{"rowstep_th_hi", 2, 2, 1, 4001, 0, 0,    0};
    tbl[7] = '{"col4095_gx",    3, 0, 0, 0,    0, 4095, 12};
    tbl[8] = '{"col4095_pass",  3, 3, 0, 0,    0, 4095, 18};
    tbl[9] = '{"colstep_gaps",  1, 0, 0, 0,    1, 4000, 12};

    errors  = 0;
    checks  = 0;
    iRST    = 1'b1;
    iDVAL   = 1'b0;
    iSOF    = 1'b0;
    iMODE   = 2'b00;
    iTH_EN  = 1'b0;
    iTHRESH = '0;
    iDATA   = '0;
    clear_stats(0);
    repeat (3) @(posedge iCLK);
    #1;
    check("reset_odval", int'(oDVAL), 0);
    check("reset_osof", int'(oSOF), 0);
    check("reset_odata", int'(oDATA), 0);
    iRST = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;

    for (int t = 0; t < 10; t++) begin
      clear_stats(tbl[t].nz_val);
      send_frame(tbl[t].pat, tbl[t].mode, tbl[t].th_en, tbl[t].th, tbl[t].gaps, 1, 64);
      drain();
      frame_stats(tbl[t].name, tbl[t].nz_cnt);
    end

    // Reset in the middle of row 3, then a fresh frame without SOF.
    clear_stats(4000);
    send_frame(1, 0, 0, 0, 0, 1, 28);
    check("pre_rst_odval", int'(oDVAL), 1);
    iRST = 1'b1;
    #1;
    check("async_rst_odval", int'(oDVAL), 0);
    check("async_rst_odata", int'(oDATA), 0);
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    @(posedge iCLK);
    #1;
    clear_stats(4000);
    send_frame(1, 0, 0, 0, 0, 0, 64);
    drain();
    frame_stats("post_reset", 12);

    // SOF mid-line must restart position tracking.
    send_frame(4, 0, 0, 0, 0, 1, 5);
    drain();
    clear_stats(4000);
    send_frame(1, 0, 0, 0, 0, 1, 64);
    drain();
    frame_stats("sof_resync", 12);

    for (int t = 0; t < 6; t++) begin
      clear_stats(0);
      send_frame(4, (t == 5) ? -1 : int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4095)), 1, 1, 64);
      drain();
      check("rand_count", out_cnt, 64);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
